// File: rtl/adc_byte_streamer.sv
// adc_byte_streamer: captures a requested number of 10-bit ADC samples into a
// small ring buffer and streams each one as two little-endian bytes to an FTDI
// write FIFO, at most one byte every two clocks, stalling on wr_full.
// Optional feature macro: ADC_STREAM_HEADER_EN (prefixes each acquisition with
// the header bytes 0xA5, 0x5A).
module adc_byte_streamer #(
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [9:0]       adc_data,
    input  logic             adc_valid,
    input  logic             wr_full,
    output logic             wr_en,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
`ifdef ADC_STREAM_HEADER_EN
        HEADER,
`endif
        CAPTURE,
        DRAIN,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [9:0]       mem [BUF_DEPTH];
    logic [9:0]       head;
    logic             phase;        // 0: next byte is byte0, 1: byte1
`ifdef ADC_STREAM_HEADER_EN
    logic             hdr_idx;      // 0: 0xA5 pending, 1: 0x5A pending
`endif

    logic             buf_empty;
    logic             buf_full;
    logic             accept;
    logic             sample;
    logic             push;
    logic             pop;
    logic             stream_state;
    logic             have_byte;
    logic [7:0]       byte_nxt;
    logic             emit;

    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    // Buffer, byte-source selection and write-strobe decision.
    always_comb begin
        accept       = (state == IDLE) && start;
        sample       = (state == CAPTURE) && adc_valid;
        push         = sample && !buf_full;
        stream_state = (state == CAPTURE) || (state == DRAIN);
        have_byte    = 1'b0;
        byte_nxt     = '0;
        if (stream_state && !buf_empty) begin
            have_byte = 1'b1;
            byte_nxt  = phase ? {6'b0, head[9:8]} : head[7:0];
        end
`ifdef ADC_STREAM_HEADER_EN
        if (state == HEADER) begin
            have_byte = 1'b1;
            byte_nxt  = hdr_idx ? 8'h5A : 8'hA5;
        end
`endif
        emit = have_byte && !wr_full && !wr_en;
        pop  = stream_state && emit && phase;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ADC_STREAM_HEADER_EN
                    state_nxt = HEADER;
`else
                    state_nxt = (num_samples == '0) ? DRAIN : CAPTURE;
`endif
                end
            end
`ifdef ADC_STREAM_HEADER_EN
            HEADER: begin
                if (emit && hdr_idx)
                    state_nxt = (remaining == '0) ? DRAIN : CAPTURE;
            end
`endif
            CAPTURE: begin
                if ((remaining == '0) || (adc_valid && (remaining == CNT_W'(1))))
                    state_nxt = DRAIN;
            end
            // Wait for the final byte's strobe cycle to pass before finishing.
            DRAIN: begin
                if (buf_empty && !wr_en)
                    state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counters, pointers, sticky overflow and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            phase     <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
`ifdef ADC_STREAM_HEADER_EN
            hdr_idx   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                remaining <= num_samples;
                overflow  <= 1'b0;
            end else if (sample) begin
                remaining <= remaining - CNT_W'(1);
                if (buf_full)
                    overflow <= 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (stream_state && emit)
                phase <= ~phase;
`ifdef ADC_STREAM_HEADER_EN
            if (accept)
                hdr_idx <= 1'b0;
            else if ((state == HEADER) && emit)
                hdr_idx <= ~hdr_idx;
`endif
            wr_en <= emit;
            if (emit)
                wr_data <= byte_nxt;
        end
    end

    // Sample storage; emptiness is governed by the pointers alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= adc_data;
    end

endmodule

// File: tb/tb_adc_byte_streamer.sv
// Self-checking bench for adc_byte_streamer: expected bytes are queued when
// samples are driven and compared as the DUT writes them.
module tb_adc_byte_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic [9:0]  adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        wr_full = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        overflow;

    adc_byte_streamer #(.BUF_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .adc_data(adc_data), .adc_valid(adc_valid), .wr_full(wr_full),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  exp_q[$];
    logic        lossy = 1'b0;
    logic        pair_pos = 1'b0;
    logic        prev_en = 1'b0;
    logic        prev_full = 1'b0;
    int unsigned done_cnt = 0;
    int unsigned bytes_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [9:0] d);
        exp_q.push_back(d[7:0]);
        exp_q.push_back({6'b0, d[9:8]});
    endtask

    task automatic flush();
        exp_q.delete();
        pair_pos = 1'b0;
        lossy = 1'b0;
        bytes_run = 0;
    endtask

    task automatic start_acq(input logic [15:0] n);
`ifdef ADC_STREAM_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
`endif
        bytes_run = 0;
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [9:0] d, input int unsigned gap, input logic expect_it);
        repeat (gap) tick();
        adc_data = d;
        adc_valid = 1'b1;
        if (expect_it) push_sample(d);
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned base = done_cnt;
        int unsigned k = 0;
        while (done_cnt == base && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 32'(done_cnt - base), 32'd1);
        repeat (3) tick();
        check({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Byte monitor: spacing rule, stall rule, scoreboard compare, done count.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && wr_en) begin
            bytes_run++;
            check("wr_spacing", 32'(prev_en), 32'd0);
            check("wr_while_full", 32'(prev_full), 32'd0);
            if (lossy && !pair_pos) begin
                while (exp_q.size() >= 2 && exp_q[0] !== wr_data) begin
                    void'(exp_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
            if (exp_q.size() == 0)
                check("extra_byte", 32'(exp_q.size()), 32'd1);
            else
                check("byte", 32'(wr_data), 32'(exp_q.pop_front()));
            if (lossy) pair_pos = ~pair_pos;
        end
        prev_en = wr_en;
        prev_full = wr_full;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned busy_cycles;
        int unsigned stall_wr;
        logic [9:0] d;

        // Reset state
        repeat (2) tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Three samples, valid every 4th cycle
        flush();
        start_acq(16'd3);
        check("t1_busy", 32'(busy), 32'd1);
        feed(10'h3FF, 3, 1'b1);
        feed(10'h001, 3, 1'b1);
        feed(10'h2AA, 3, 1'b1);
        wait_done("t1", 200);
        check("t1_left", 32'(exp_q.size()), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Twenty back-to-back samples overrun the 8-entry buffer
        flush();
        lossy = 1'b1;
        start_acq(16'd20);
        for (int unsigned i = 0; i < 20; i++)
            feed({2'(i % 4), 8'(i * 7)}, 0, 1'b1);
        wait_done("t2", 400);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_even", 32'(bytes_run % 2), 32'd0);
`ifdef ADC_STREAM_HEADER_EN
        check("t2_le40", 32'(bytes_run <= 42), 32'd1);
`else
        check("t2_le40", 32'(bytes_run <= 40), 32'd1);
`endif
        flush();

        // 50-cycle stall mid-stream
        start_acq(16'd6);
        for (int unsigned i = 0; i < 2; i++)
            feed(10'($urandom_range(0, 1023)), 1, 1'b1);
        wr_full = 1'b1;
        stall_wr = 0;
        for (int unsigned k = 0; k < 50; k++) begin
            if (k < 8 && (k % 2) == 1) begin
                d = 10'($urandom_range(0, 1023));
                adc_data = d;
                adc_valid = 1'b1;
                push_sample(d);
            end else begin
                adc_valid = 1'b0;
            end
            tick();
            if (wr_en) stall_wr++;
        end
        adc_valid = 1'b0;
        wr_full = 1'b0;
        check("t3_stall_wr", 32'(stall_wr), 32'd0);
        wait_done("t3", 300);
        check("t3_left", 32'(exp_q.size()), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd0);

        // Zero-sample acquisition
        flush();
        start_acq(16'd0);
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            tick();
        end
        check("t4_busy_ended", 32'(busy), 32'd0);
`ifndef ADC_STREAM_HEADER_EN
        check("t4_busy_le2", 32'(busy_cycles <= 2), 32'd1);
`endif
        tick();
        check("t4_left", 32'(exp_q.size()), 32'd0);

        // Reset while draining four buffered samples
        flush();
        start_acq(16'd4);
        repeat (6) tick();
        wr_full = 1'b1;
        for (int unsigned i = 0; i < 4; i++)
            feed(10'(100 + i), 0, 1'b0);
        repeat (2) tick();
        check("t5_busy_drain", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_wr_en", 32'(wr_en), 32'd0);
        check("t5_wr_data", 32'(wr_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        flush();
        rst = 1'b0;
        wr_full = 1'b0;
        tick();
        start_acq(16'd2);
        feed(10'h155, 1, 1'b1);
        feed(10'h0C3, 1, 1'b1);
        wait_done("t5", 200);
        check("t5_left", 32'(exp_q.size()), 32'd0);

        // Second start during capture is ignored
        flush();
        start_acq(16'd3);
        feed(10'h211, 1, 1'b1);
        num_samples = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(10'h09E, 1, 1'b1);
        feed(10'h3C0, 1, 1'b1);
        feed(10'h111, 1, 1'b0);
        feed(10'h222, 1, 1'b0);
        wait_done("t6", 300);
        repeat (10) tick();
        check("t6_left", 32'(exp_q.size()), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_byte_streamer.md
ADC_BYTE_STREAMER -- requirements
Module: adc_byte_streamer

Interface
REQ-001 Parameters: BUF_DEPTH, default 8, sample-buffer entries (power of 2); CNT_W, default 16, width of num_samples.
REQ-002 clk  in  1  system clock (24 MHz domain shared with FIFO rw_clk).
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle acquisition request.
REQ-005 num_samples  in  CNT_W  ADC strobes per acquisition; sampled on accepted start.
REQ-006 adc_data  in  10  ADC sample.
REQ-007 adc_valid  in  1  adc_data valid this cycle.
REQ-008 wr_full  in  1  downstream FTDI write FIFO full.
REQ-009 wr_en  out  1  registered byte-write strobe to FTDI write FIFO.
REQ-010 wr_data  out  8  registered byte, valid when wr_en=1.
REQ-011 busy  out  1  acquisition or drain in progress.
REQ-012 done  out  1  single-cycle pulse at acquisition end.
REQ-013 overflow  out  1  sticky; set when any sample is dropped.

Function
REQ-014 States: IDLE, HEADER, CAPTURE, DRAIN, FINISH; one-hot or binary at implementer's choice.
REQ-015 IDLE: start=1 -> latch num_samples, clear overflow, enter HEADER (macro defined) or CAPTURE; busy=1 from next cycle.
REQ-016 start while busy=1 shall be ignored, with no effect on any state or counter.
REQ-017 start with num_samples=0: no samples captured; after any header, go to FINISH.
REQ-018 CAPTURE: each adc_valid=1 decrements remaining count; sample pushed to buffer if not full, else dropped and overflow set.
REQ-019 Count reaching 0 -> DRAIN; adc_valid ignored outside CAPTURE.
REQ-020 Each sample emits two bytes, little-endian: byte0=adc_data[7:0], byte1={6'b0, adc_data[9:8]}.
REQ-021 Write rule: wr_en asserted for exactly one cycle; set only when wr_full=0 at that edge and wr_en=0 in the current cycle (max 1 byte per 2 clocks).
REQ-022 wr_full=1 stalls output; no byte is lost or duplicated; wr_data holds until written.
REQ-023 Byte emission runs concurrently with capture; a simultaneous buffer push and pop in one cycle are both honoured.
REQ-024 DRAIN: continue emitting until buffer empty and last byte1 written -> FINISH.
REQ-025 FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-026 Buffer pointers wrap modulo BUF_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-027 rst=1 at any edge, including mid-acquisition: state IDLE, buffer emptied, counters 0, wr_en=0, wr_data=0, busy=0, done=0, overflow=0.
REQ-028 No partial byte pair is emitted after reset deasserts.

Configuration
REQ-029 Macro ADC_STREAM_HEADER_EN defined: HEADER state emits 0xA5 then 0x5A under REQ-021 before capture begins; adc_valid ignored during HEADER.
REQ-030 Macro undefined: HEADER state absent; IDLE goes directly to CAPTURE; output stream contains sample bytes only.

Verification
REQ-031 num_samples=3, adc_valid every 4th cycle, data 0x3FF,0x001,0x2AA, wr_full=0 -> bytes [A5 5A] FF 03 01 00 AA 02, done once, overflow=0.
REQ-032 num_samples=20, adc_valid every cycle, BUF_DEPTH=8 -> overflow=1, emitted byte count even and <=40, every pair well-formed, done once.
REQ-033 wr_full held high 50 cycles mid-stream -> wr_en stays 0 throughout; stream resumes with no gap or repeat.
REQ-034 start with num_samples=0 -> only header bytes (or none), done pulse, busy high <=2 cycles without macro.
REQ-035 rst asserted during DRAIN with 4 buffered samples -> next cycle all outputs 0; new start yields a clean stream.
REQ-036 second start during CAPTURE -> ignored; total bytes match the first num_samples only.
